round_dealer: RTL
=================

# round_dealer

Round sequencer for the bell card game. Draws two pseudo-random cards per round (colours `c1`/`c2`, numbers `n1`/`n2`) and presents them to the judging logic. Runs a per-round countdown `count` that the scorer awards as points, and advances the round when the scorer raises `finish` or the countdown expires. It sits directly upstream of `is_right` and `score_control`.

## Interface
Parameters:
- `COUNT_INIT`, 8'd100: countdown start value per round; must be ≥1.
- `ROUNDS`, 10: rounds per game, range 1..15.
- `GAP_TICKS`, 3: ticks with cards hidden between rounds, range 1..255.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: level; begins a game from IDLE or DONE.
- `tick` in 1: one-cycle time-base enable.
- `finish` in 1: from `score_control`; a bell press has been judged.
- `c1`, `c2` out 2: card colours, 0..3.
- `n1`, `n2` out 3: card numbers, 1..5.
- `count` out 8: remaining round points.
- `cards_valid` out 1: high only in SHOW.
- `round` out 4: current round, 1..ROUNDS; 0 in IDLE.
- `timeout` out 1: one-cycle pulse when the countdown expires.
- `game_over` out 1: high in DONE.

## Operation
- 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Steps every cycle that `rst`=1, in all states.
  - Loads `SEED` on reset.
- Card draw from the LFSR value `L` in the DEAL cycle:
  - `c1`=L[4:3], `c2`=L[12:11].
  - `n1`=map(L[2:0]), `n2`=map(L[10:8]).
  - map(r) = r+1 for r<5, and r−4 for r≥5.
- States:
  - IDLE: all outputs 0. `start`=1 → DEAL, `round`←0.
  - DEAL, one cycle: draw cards, `count`←COUNT_INIT, `round`←round+1 → SHOW. `tick` ignored.
  - SHOW: `cards_valid`=1.
    - `finish`=1 → GAP. Cards and `count` hold.
    - Otherwise, `tick`=1 → `count`←count−1.
    - If that decrement reaches 0: `timeout` pulses and state → GAP.
    - `start` ignored.
  - GAP: `cards_valid`=0. Cards, `count` and `round` hold. Counts GAP_TICKS ticks, then:
    - `round`==ROUNDS → DONE.
    - Otherwise → DEAL.
    - `finish` ignored.
  - DONE: `game_over`=1; last cards and `round` hold. `start`=1 → DEAL with `round`←0 first, so the new game begins at round 1.
- Same cycle `finish` and the expiring `tick` in SHOW: `finish` wins. `timeout` stays 0 and `count` stays 1.
- `count` never underflows. It only decrements in SHOW.

## Timing
- Reset values: state IDLE; `c1`, `c2`, `n1`, `n2`, `count`, `round` = 0; `cards_valid`, `timeout`, `game_over` = 0; LFSR=SEED.
- Reset at any point, including mid-round, returns to these values the next edge.
- All outputs are registered.
  - `start` seen at edge k → DEAL during cycle k+1.
  - Cards, `count`=COUNT_INIT and `cards_valid`=1 are visible from k+2.
- `finish` sampled at edge k in SHOW → `cards_valid`=0 from k+1.
- `timeout` is high for exactly the cycle after the expiring tick, concurrent with the first GAP cycle.
- Full round with no press and `tick` tied high: 1 DEAL + COUNT_INIT SHOW cycles + GAP_TICKS GAP cycles.

## Structure
- Shared package `bell_pkg`:
  - colour/number/score widths (2/3/8);
  - dealer state enum (IDLE, DEAL, SHOW, GAP, DONE);
  - `card_num` mapping function, shared with any card-display logic.
- Sub-module `lfsr16`: clk, rst, seed parameter, 16-bit state output.
- The dealer FSM, countdown and gap counter live in `round_dealer`.

## Test plan
- Reset behaviour: reset for 2 cycles, then release with `start`=0 for 20 cycles → all outputs 0, `round`=0. A reference LFSR model matches starting from 16'hACE1.
- Timeout path: COUNT_INIT=5, `tick`=1, pulse `start` → `count` goes 5,4,3,2,1,0 over SHOW; `timeout` is a single-cycle pulse; `cards_valid` falls; round 2 deals 4 cycles later (GAP_TICKS=3 plus DEAL).
- Finish path: `finish` pulse at `count`=60 with COUNT_INIT=100 → `count` holds 60 through GAP; `timeout`=0; next DEAL reloads 100.
- Simultaneous events: `finish` and the expiring tick in the same cycle at `count`=1 → `timeout`=0, `count`=1, state GAP.
- Full game: ROUNDS=3 with repeated timeouts → `round` 1,2,3, then `game_over`=1. Every dealt `n1`/`n2` is in 1..5 and matches map(LFSR); `start` then restarts at `round`=1.
- Mid-operation reset: assert `rst`=0 during SHOW of round 2 → next edge gives IDLE, all outputs 0. The LFSR sequence after release repeats the sequence after the first reset.

Source files
------------

// File: rtl/bell_pkg.sv
// Shared types and helpers for the bell card game datapath.
package bell_pkg;

   localparam int COLOR_W = 2;
   localparam int NUM_W   = 3;
   localparam int SCORE_W = 8;

   // Dealer sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DEAL = 3'd1,
      ST_SHOW = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } dealer_state_t;

   // Fold a 3-bit random value onto card numbers 1..5.
   function automatic logic [NUM_W-1:0] card_num(input logic [NUM_W-1:0] r);
      return (r < 3'd5) ? (r + 3'd1) : (r - 3'd4);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, free-running while out of reset.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] o_state
);

   logic [15:0] r_state;

   // Shift right; when a one falls out of bit 0, apply the feedback taps.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= SEED;
      end else begin
         r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/round_dealer.sv
// Round sequencer: deals two cards per round, runs the countdown and the
// inter-round gap, and tracks the round number across a game.
module round_dealer
   import bell_pkg::*;
#(
   parameter logic [7:0]  COUNT_INIT = 8'd100,
   parameter int          ROUNDS     = 10,
   parameter int          GAP_TICKS  = 3,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               tick,
   input  logic               finish,
   output logic [COLOR_W-1:0] c1,
   output logic [COLOR_W-1:0] c2,
   output logic [NUM_W-1:0]   n1,
   output logic [NUM_W-1:0]   n2,
   output logic [SCORE_W-1:0] count,
   output logic               cards_valid,
   output logic [3:0]         round,
   output logic               timeout,
   output logic               game_over
);

   localparam logic [3:0] ROUNDS_L = ROUNDS[3:0];
   localparam logic [7:0] GAP_L    = GAP_TICKS[7:0];

   logic [15:0] w_lfsr;
   logic        w_lfsr_unused;

   dealer_state_t      r_state, w_state_next;
   logic [COLOR_W-1:0] r_c1, r_c2, w_c1_next, w_c2_next;
   logic [NUM_W-1:0]   r_n1, r_n2, w_n1_next, w_n2_next;
   logic [SCORE_W-1:0] r_count, w_count_next;
   logic [3:0]         r_round, w_round_next;
   logic [7:0]         r_gap, w_gap_next, w_gap_inc;
   logic               r_cards_valid, w_cards_valid_next;
   logic               r_timeout, w_timeout_next;
   logic               r_game_over, w_game_over_next;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .o_state (w_lfsr)
   );

   // Spare LFSR bits that the card draw does not look at.
   assign w_lfsr_unused = ^{w_lfsr[15:13], w_lfsr[7:5]};

   assign w_gap_inc = r_gap + 8'd1;

   // Next-state and next-output logic; everything holds unless a rule changes it.
   always_comb begin
      w_state_next       = r_state;
      w_c1_next          = r_c1;
      w_c2_next          = r_c2;
      w_n1_next          = r_n1;
      w_n2_next          = r_n2;
      w_count_next       = r_count;
      w_round_next       = r_round;
      w_gap_next         = r_gap;
      w_cards_valid_next = r_cards_valid;
      w_timeout_next     = 1'b0;
      w_game_over_next   = r_game_over;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_DEAL;
               w_round_next = 4'd0;
            end
         end
         ST_DEAL: begin
            w_c1_next          = w_lfsr[4:3];
            w_c2_next          = w_lfsr[12:11];
            w_n1_next          = card_num(w_lfsr[2:0]);
            w_n2_next          = card_num(w_lfsr[10:8]);
            w_count_next       = COUNT_INIT;
            w_round_next       = r_round + 4'd1;
            w_cards_valid_next = 1'b1;
            w_state_next       = ST_SHOW;
         end
         ST_SHOW: begin
            // A judged press wins over an expiring tick in the same cycle.
            if (finish) begin
               w_state_next       = ST_GAP;
               w_cards_valid_next = 1'b0;
               w_gap_next         = 8'd0;
            end else if (tick && (r_count != 8'd0)) begin
               w_count_next = r_count - 8'd1;
               if (r_count == 8'd1) begin
                  w_timeout_next     = 1'b1;
                  w_state_next       = ST_GAP;
                  w_cards_valid_next = 1'b0;
                  w_gap_next         = 8'd0;
               end
            end
         end
         ST_GAP: begin
            if (tick) begin
               w_gap_next = w_gap_inc;
               if (w_gap_inc == GAP_L) begin
                  if (r_round == ROUNDS_L) begin
                     w_state_next     = ST_DONE;
                     w_game_over_next = 1'b1;
                  end else begin
                     w_state_next = ST_DEAL;
                  end
               end
            end
         end
         ST_DONE: begin
            if (start) begin
               w_state_next     = ST_DEAL;
               w_round_next     = 4'd0;
               w_game_over_next = 1'b0;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_c1          <= '0;
         r_c2          <= '0;
         r_n1          <= '0;
         r_n2          <= '0;
         r_count       <= '0;
         r_round       <= '0;
         r_gap         <= '0;
         r_cards_valid <= 1'b0;
         r_timeout     <= 1'b0;
         r_game_over   <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_c1          <= w_c1_next;
         r_c2          <= w_c2_next;
         r_n1          <= w_n1_next;
         r_n2          <= w_n2_next;
         r_count       <= w_count_next;
         r_round       <= w_round_next;
         r_gap         <= w_gap_next;
         r_cards_valid <= w_cards_valid_next;
         r_timeout     <= w_timeout_next;
         r_game_over   <= w_game_over_next;
      end
   end

   assign c1          = r_c1;
   assign c2          = r_c2;
   assign n1          = r_n1;
   assign n2          = r_n2;
   assign count       = r_count;
   assign round       = r_round;
   assign cards_valid = r_cards_valid;
   assign timeout     = r_timeout;
   assign game_over   = r_game_over;

endmodule
